tw_axis_frame_monitor: RTL and testbench

Pass-through AXI4-Stream stage placed directly downstream of the torwave generator's 64-bit `m0_data` master port and upstream of the Ethernet MAC TX. It buffers the stream through a 2-entry skid register, checks the `tkeep` and length rules for every frame, and keeps saturating frame and byte statistics. Per-10 ms window counts are latched on `radio_start_10ms` so software can confirm that the generated traffic rate matches the radio frame timing.

---
 rtl/tw_stream_pkg.sv | 29 ++
 rtl/tw_axis_frame_monitor_if.sv | 21 ++
 rtl/tw_axis_skid.sv | 51 +++++
 rtl/tw_axis_frame_monitor.sv | 147 ++++++++++++++
 tb/tb_tw_axis_frame_monitor.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tw_stream_pkg.sv
// Shared definitions for the torwave AXI4-Stream monitor path.
// Holds beat geometry, tkeep helpers and the frame-tracking state type.
package tw_stream_pkg;

   localparam int unsigned BEAT_BYTES = 8;
   localparam int unsigned DATA_W     = 8 * BEAT_BYTES;
   // Payload order: {tdata, tkeep, tlast, tuser}
   localparam int unsigned PAYLOAD_W  = DATA_W + BEAT_BYTES + 2;

   typedef enum logic {
      StIdle,
      StInFrame
   } frame_state_e;

   function automatic logic [3:0] keep_popcount(logic [7:0] keep);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, keep[i]};
      end
      return n;
   endfunction

   // A closing beat must carry a contiguous run of low bytes, at least one.
   function automatic logic keep_is_last_legal(logic [7:0] keep);
      return keep inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
   endfunction

endpackage

// File: rtl/tw_axis_frame_monitor_if.sv
// 64-bit AXI4-Stream bundle used on both sides of the frame monitor.
interface tw_axis_frame_monitor_if;

   logic [tw_stream_pkg::DATA_W-1:0]     tdata;
   logic [tw_stream_pkg::BEAT_BYTES-1:0] tkeep;
   logic                                 tvalid;
   logic                                 tlast;
   logic                                 tuser;
   logic                                 tready;

   modport master (
      output tdata, tkeep, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tuser,
      output tready
   );

endinterface

// File: rtl/tw_axis_skid.sv
// Two-entry register slice: an output register plus one skid entry.
// Input ready is registered and simply means the skid entry is empty.
module tw_axis_skid #(
   parameter int unsigned Width = 74
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [Width-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [Width-1:0] skid_q;
   logic             skid_valid_q;
   logic             accept;
   logic             advance;

   assign accept  = in_valid && in_ready;
   assign advance = out_ready || !out_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         in_ready     <= 1'b1;
      end else if (advance) begin
         if (skid_valid_q) begin
            // in_ready is low here, so nothing new can arrive this cycle
            out_data     <= skid_q;
            out_valid    <= 1'b1;
            skid_valid_q <= 1'b0;
            in_ready     <= 1'b1;
         end else begin
            out_valid <= accept;
            if (accept) begin
               out_data <= in_data;
            end
         end
      end else if (accept) begin
         skid_q       <= in_data;
         skid_valid_q <= 1'b1;
         in_ready     <= 1'b0;
      end
   end

endmodule

// File: rtl/tw_axis_frame_monitor.sv
// Pass-through AXIS stage between the torwave generator and the MAC that
// validates tkeep/length per frame and keeps total and 10 ms window statistics.
module tw_axis_frame_monitor
   import tw_stream_pkg::*;
#(
   parameter int unsigned MAX_FRAME_BYTES = 9600,
   parameter int unsigned CNT_WIDTH       = 32
) (
   input  logic                  s_axis_aclk,
   input  logic                  s_axis_aresetn,
   tw_axis_frame_monitor_if.slave  s_data,
   tw_axis_frame_monitor_if.master m_data,
   input  logic                  radio_start_10ms,
   input  logic                  clear_stats,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic [CNT_WIDTH-1:0]  byte_count,
   output logic [15:0]           win_frames,
   output logic [31:0]           win_bytes,
   output logic                  err_keep,
   output logic                  err_oversize,
   output logic [15:0]           err_count,
   output logic                  frame_active
);

   logic                 s_ready;
   logic [PAYLOAD_W-1:0] out_payload;

   tw_axis_skid #(
      .Width (PAYLOAD_W)
   ) u_skid (
      .clk       (s_axis_aclk),
      .rst_n     (s_axis_aresetn),
      .in_data   ({s_data.tdata, s_data.tkeep, s_data.tlast, s_data.tuser}),
      .in_valid  (s_data.tvalid),
      .in_ready  (s_ready),
      .out_data  (out_payload),
      .out_valid (m_data.tvalid),
      .out_ready (m_data.tready)
   );

   assign s_data.tready = s_ready;
   assign {m_data.tdata, m_data.tkeep, m_data.tlast, m_data.tuser} = out_payload;

   frame_state_e state_q;
   logic [15:0]  len_q;
   logic         bad_q;
   logic [15:0]  wf_q;
   logic [31:0]  wb_q;

   logic                 acc;
   logic                 done;
   logic [3:0]           beat_bytes;
   logic [3:0]           add_bytes;
   logic                 keep_bad;
   logic [16:0]          len_sum;
   logic [15:0]          len_next;
   logic                 over;
   logic                 frame_bad;
   logic [16:0]          wf_sum;
   logic [15:0]          wf_next;
   logic [32:0]          wb_sum;
   logic [31:0]          wb_next;
   logic [CNT_WIDTH:0]   byte_sum;
   logic [CNT_WIDTH-1:0] byte_next;
   logic [CNT_WIDTH-1:0] frame_next;
   logic [15:0]          err_next;

   assign acc        = s_data.tvalid && s_ready;
   assign done       = acc && s_data.tlast;
   assign beat_bytes = keep_popcount(s_data.tkeep);
   assign add_bytes  = acc ? beat_bytes : 4'd0;
   assign keep_bad   = s_data.tlast ? !keep_is_last_legal(s_data.tkeep)
                                    : (s_data.tkeep != 8'hFF);

   assign len_sum   = {1'b0, len_q} + 17'(beat_bytes);
   assign len_next  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
   assign over      = 32'(len_next) > MAX_FRAME_BYTES;
   assign frame_bad = bad_q || keep_bad || over;

   // Window sums already include the current cycle so a boundary pulse can close on them
   assign wf_sum  = {1'b0, wf_q} + 17'(done);
   assign wf_next = wf_sum[16] ? 16'hFFFF : wf_sum[15:0];
   assign wb_sum  = {1'b0, wb_q} + 33'(add_bytes);
   assign wb_next = wb_sum[32] ? 32'hFFFF_FFFF : wb_sum[31:0];

   assign byte_sum   = {1'b0, byte_count} + (CNT_WIDTH + 1)'(beat_bytes);
   assign byte_next  = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
   assign frame_next = (frame_count == '1) ? frame_count : frame_count + CNT_WIDTH'(1);
   assign err_next   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

   assign frame_active = (state_q == StInFrame);

   // Frame tracking is deliberately untouched by clear_stats
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         state_q <= StIdle;
         len_q   <= '0;
         bad_q   <= 1'b0;
      end else if (acc) begin
         if (s_data.tlast) begin
            state_q <= StIdle;
            len_q   <= '0;
            bad_q   <= 1'b0;
         end else begin
            state_q <= StInFrame;
            len_q   <= len_next;
            bad_q   <= frame_bad;
         end
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn || clear_stats) begin
         frame_count  <= '0;
         byte_count   <= '0;
         err_count    <= '0;
         err_keep     <= 1'b0;
         err_oversize <= 1'b0;
         wf_q         <= '0;
         wb_q         <= '0;
         win_frames   <= '0;
         win_bytes    <= '0;
      end else begin
         if (acc) begin
            byte_count   <= byte_next;
            err_keep     <= err_keep | keep_bad;
            err_oversize <= err_oversize | over;
            if (s_data.tlast) begin
               frame_count <= frame_next;
               if (frame_bad) begin
                  err_count <= err_next;
               end
            end
         end
         if (radio_start_10ms) begin
            win_frames <= wf_next;
            win_bytes  <= wb_next;
            wf_q       <= '0;
            wb_q       <= '0;
         end else begin
            wf_q <= wf_next;
            wb_q <= wb_next;
         end
      end
   end

endmodule

// File: tb/tb_tw_axis_frame_monitor.sv
// Self-checking bench for tw_axis_frame_monitor: directed test-plan steps followed by
// randomized traffic, compared against a frame-level reference model and a beat scoreboard.
module tb_tw_axis_frame_monitor;

   localparam int unsigned MAXB = 64;
   localparam longint      CMAX = 64'hFFFF_FFFF;

   logic clk;
   logic rst_n;
   logic radio;
   logic clr;

   logic [31:0] frame_count;
   logic [31:0] byte_count;
   logic [15:0] win_frames;
   logic [31:0] win_bytes;
   logic        err_keep;
   logic        err_oversize;
   logic [15:0] err_count;
   logic        frame_active;

   tw_axis_frame_monitor_if s_if ();
   tw_axis_frame_monitor_if m_if ();

   tw_axis_frame_monitor #(
      .MAX_FRAME_BYTES (MAXB),
      .CNT_WIDTH       (32)
   ) dut (
      .s_axis_aclk      (clk),
      .s_axis_aresetn   (rst_n),
      .s_data           (s_if),
      .m_data           (m_if),
      .radio_start_10ms (radio),
      .clear_stats      (clr),
      .frame_count      (frame_count),
      .byte_count       (byte_count),
      .win_frames       (win_frames),
      .win_bytes        (win_bytes),
      .err_keep         (err_keep),
      .err_oversize     (err_oversize),
      .err_count        (err_count),
      .frame_active     (frame_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   longint md_frames, md_bytes, md_wf, md_wb, md_winf, md_winb, md_errc;
   logic   md_errk, md_erro, md_bad, md_inf;
   int     md_len;

   logic [73:0] sb[$];
   int          rdy_mode;
   logic        rand_ctl;
   logic [1:0]  rdy_hist;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint smin(longint a, longint m);
      return (a > m) ? m : a;
   endfunction

   function automatic logic legal_last(logic [7:0] k);
      for (int n = 1; n <= 8; n++) begin
         if (int'(k) == (1 << n) - 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_clear_stats();
      md_frames = 0; md_bytes = 0; md_wf = 0; md_wb = 0;
      md_winf = 0; md_winb = 0; md_errc = 0; md_errk = 0; md_erro = 0;
   endtask

   task automatic model_update(logic acc, logic [7:0] keep, logic last, logic rad, logic clr_i);
      int     nb, newlen;
      logic   kb, over, badn;
      longint add_f, add_b;
      nb     = $countones(keep);
      kb     = last ? !legal_last(keep) : (keep != 8'hFF);
      newlen = (md_len + nb > 65535) ? 65535 : md_len + nb;
      over   = acc && (newlen > int'(MAXB));
      badn   = md_bad || kb || over;
      add_f  = (acc && last) ? 1 : 0;
      add_b  = acc ? longint'(nb) : 0;
      if (clr_i) begin
         model_clear_stats();
      end else begin
         md_frames = smin(md_frames + add_f, CMAX);
         md_bytes  = smin(md_bytes + add_b, CMAX);
         if (acc && last && badn) md_errc = smin(md_errc + 1, 65535);
         if (acc) begin
            md_errk = md_errk | kb;
            md_erro = md_erro | over;
         end
         if (rad) begin
            md_winf = smin(md_wf + add_f, 65535);
            md_winb = smin(md_wb + add_b, CMAX);
            md_wf   = 0;
            md_wb   = 0;
         end else begin
            md_wf = smin(md_wf + add_f, 65535);
            md_wb = smin(md_wb + add_b, CMAX);
         end
      end
      if (acc) begin
         md_len = last ? 0 : newlen;
         md_bad = last ? 1'b0 : badn;
         md_inf = !last;
      end
   endtask

   task automatic check_stats();
      chk("frame_count", frame_count, md_frames);
      chk("byte_count", byte_count, md_bytes);
      chk("win_frames", win_frames, md_winf);
      chk("win_bytes", win_bytes, md_winb);
      chk("err_keep", err_keep, md_errk);
      chk("err_oversize", err_oversize, md_erro);
      chk("err_count", err_count, md_errc);
      chk("frame_active", frame_active, md_inf);
   endtask

   // One clock: evaluate handshakes, advance model, clock, then check.
   task automatic cycle();
      logic        acc, mfire;
      logic [73:0] in_pl, exp_pl;
      case (rdy_mode)
         0:       m_if.tready = 1'b1;
         1:       m_if.tready = ~m_if.tready;
         default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
      if (rand_ctl) begin
         radio = ($urandom_range(0, 19) == 0);
         clr   = ($urandom_range(0, 79) == 0);
      end
      acc   = s_if.tvalid && s_if.tready;
      mfire = m_if.tvalid && m_if.tready;
      in_pl = {s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser};
      if (mfire) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_beat", 1, 0);
         end else begin
            exp_pl = sb.pop_front();
            chk("out_payload", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, exp_pl);
         end
      end
      if (acc) sb.push_back(in_pl);
      model_update(acc, s_if.tkeep, s_if.tlast, radio, clr);
      rdy_hist = {rdy_hist[0], m_if.tready};
      @(posedge clk);
      #1;
      check_stats();
      if (rdy_hist == 2'b11) begin
         chk("latency_valid", m_if.tvalid, acc);
         chk("s_ready_high", s_if.tready, 1'b1);
         if (acc) chk("latency_data", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, in_pl);
      end
      radio = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic idle(int n);
      s_if.tvalid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_beat(logic [7:0] keep, logic last);
      logic took;
      int   budget;
      budget      = 40;
      s_if.tvalid = 1'b1;
      s_if.tkeep  = keep;
      s_if.tlast  = last;
      s_if.tdata  = {$urandom, $urandom};
      s_if.tuser  = 1'($urandom);
      forever begin
         took = s_if.tready;
         cycle();
         if (took) break;
         budget--;
         if (budget == 0) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      s_if.tvalid = 1'b0;
      sb.delete();
      model_clear_stats();
      md_len   = 0;
      md_bad   = 1'b0;
      md_inf   = 1'b0;
      rdy_hist = 2'b00;
      @(posedge clk);
      #1;
      chk("rst_m_tvalid", m_if.tvalid, 1'b0);
      chk("rst_m_payload", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, 74'd0);
      chk("rst_s_tready", s_if.tready, 1'b1);
      check_stats();
      rst_n = 1'b1;
   endtask

   task automatic send_frame3();
      send_beat(8'hFF, 1'b0);
      send_beat(8'hFF, 1'b0);
      send_beat(8'h0F, 1'b1);
   endtask

   initial begin
      rst_n       = 1'b0;
      radio       = 1'b0;
      clr         = 1'b0;
      rand_ctl    = 1'b0;
      rdy_mode    = 0;
      rdy_hist    = 2'b00;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      m_if.tready = 1'b1;
      do_reset();

      // 3-beat frame with the sink always ready
      send_frame3();
      idle(2);
      chk("t1_frame_count", frame_count, 32'd1);
      chk("t1_byte_count", byte_count, 32'd20);
      chk("t1_err_count", err_count, 16'd0);

      // Same frame under 1010 backpressure
      rdy_mode = 1;
      send_frame3();
      idle(4);
      rdy_mode = 0;
      idle(2);
      chk("t2_drained", sb.size(), 0);

      // Illegal tkeep on a non-last beat and on a last beat
      clr = 1'b1;
      idle(1);
      send_beat(8'h7F, 1'b0);
      send_beat(8'hFF, 1'b1);
      send_beat(8'h05, 1'b1);
      idle(2);
      chk("t3_err_keep", err_keep, 1'b1);
      chk("t3_err_count", err_count, 16'd2);

      // 10 full beats against a 64-byte limit
      clr = 1'b1;
      idle(1);
      for (int i = 1; i <= 10; i++) begin
         send_beat(8'hFF, i == 10);
         if (i == 8) chk("t4_no_oversize_beat8", err_oversize, 1'b0);
         if (i == 9) chk("t4_oversize_beat9", err_oversize, 1'b1);
      end
      idle(1);
      chk("t4_err_count", err_count, 16'd1);

      // Window boundary coinciding with the sixth single-beat frame
      clr = 1'b1;
      idle(1);
      for (int i = 0; i < 5; i++) send_beat(8'hFF, 1'b1);
      radio = 1'b1;
      send_beat(8'hFF, 1'b1);
      chk("t5_win_frames", win_frames, 16'd6);
      chk("t5_win_bytes", win_bytes, 32'd48);
      send_beat(8'h03, 1'b1);
      radio = 1'b1;
      idle(1);
      chk("t5_next_win_frames", win_frames, 16'd1);
      chk("t5_next_win_bytes", win_bytes, 32'd2);

      // clear_stats and boundary together, with traffic in that cycle
      send_beat(8'hFF, 1'b1);
      radio = 1'b1;
      clr   = 1'b1;
      send_beat(8'hFF, 1'b1);
      chk("t6_win_frames", win_frames, 16'd0);
      chk("t6_win_bytes", win_bytes, 32'd0);
      chk("t6_frame_count", frame_count, 32'd0);
      chk("t6_byte_count", byte_count, 32'd0);

      // Randomized traffic with random backpressure, boundaries and clears
      rdy_mode = 2;
      rand_ctl = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int nbeats;
         nbeats = $urandom_range(1, 11);
         for (int b = 0; b < nbeats; b++) begin
            logic        last;
            logic [7:0]  k;
            int          n;
            last = (b == nbeats - 1);
            if (last) begin
               n = $urandom_range(1, 8);
               k = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'((1 << n) - 1);
            end else begin
               k = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
            end
            send_beat(k, last);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      rand_ctl = 1'b0;
      rdy_mode = 0;
      idle(4);
      chk("rand_drained", sb.size(), 0);

      // Reset in the middle of a frame under backpressure
      rdy_mode = 2;
      send_beat(8'hFF, 1'b0);
      send_beat(8'hFF, 1'b0);
      do_reset();
      rdy_mode = 0;
      send_beat(8'hFF, 1'b0);
      chk("post_rst_active", frame_active, 1'b1);
      send_beat(8'h01, 1'b1);
      idle(3);
      chk("post_rst_frames", frame_count, 32'd1);
      chk("post_rst_bytes", byte_count, 32'd9);
      chk("post_rst_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
